// File: rtl/test_monitor_pkg.sv
// Shared definitions for the end-of-test monitor: FSM states, status codes,
// default register indices and width defaults.
package test_monitor_pkg;

  localparam int TM_DATA_W   = 32;
  localparam int TM_ADDR_W   = 32;
  localparam int TM_DONE_REG = 26;
  localparam int TM_PASS_REG = 27;
  localparam int TM_TNUM_REG = 3;

  typedef enum logic [1:0] {
    TM_RUN  = 2'b00,
    TM_DONE = 2'b01,
    TM_TOUT = 2'b10,
    TM_HANG = 2'b11
  } tm_state_e;

  localparam logic [1:0] ST_RUNNING = 2'b00;
  localparam logic [1:0] ST_DONE    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_HANG    = 2'b11;

  function automatic logic [1:0] status_of(input tm_state_e s);
    logic [1:0] code;
    code = ST_RUNNING;
    case (s)
      TM_DONE: code = ST_DONE;
      TM_TOUT: code = ST_TIMEOUT;
      TM_HANG: code = ST_HANG;
      default: code = ST_RUNNING;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/test_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] value_d, value_q;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc && (value_q != {W{1'b1}})) begin
      value_d = value_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/test_monitor.sv
// End-of-test monitor: snoops register write-back and fetch PC, latches stop/succ.
// Optional PC self-loop hang detection is built when TEST_MONITOR_HANG_EN is defined.
import test_monitor_pkg::*;

module test_monitor #(
  parameter int DATA_W   = TM_DATA_W,
  parameter int ADDR_W   = TM_ADDR_W,
  parameter int DONE_REG = TM_DONE_REG,
  parameter int PASS_REG = TM_PASS_REG,
  parameter int TNUM_REG = TM_TNUM_REG,
  parameter int CNT_W    = 32,
  parameter int TIMEOUT  = 1_000_000,
  parameter int LOOP_CNT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              pc_vld,
  input  logic [ADDR_W-1:0] pc,
  output logic              stop,
  output logic              succ,
  output logic [1:0]        status,
  output logic [DATA_W-1:0] test_num,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam logic [4:0]       DONE_IDX  = 5'(DONE_REG);
  localparam logic [4:0]       PASS_IDX  = 5'(PASS_REG);
  localparam logic [4:0]       TNUM_IDX  = 5'(TNUM_REG);
  localparam logic [CNT_W-1:0] TOUT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam int               LC_W      = $clog2(LOOP_CNT) + 1;

  tm_state_e         state_d, state_q;
  logic              stop_d, stop_q;
  logic              succ_d, succ_q;
  logic [1:0]        status_d, status_q;
  logic [DATA_W-1:0] pass_sh_d, pass_sh_q;
  logic [DATA_W-1:0] tnum_sh_d, tnum_sh_q;
  logic [CNT_W-1:0]  cycle_val;
  logic              wr_nz, done_wr, timeout_hit, hang_hit, cyc_inc;

  // x0 is hard-wired zero, so writes to it never count even if an index parameter is 0
  assign wr_nz       = wb_en && (wb_addr != 5'd0);
  assign done_wr     = wr_nz && (wb_addr == DONE_IDX) && (wb_data == DATA_W'(1));
  assign timeout_hit = (TIMEOUT != 0) && (cycle_val == TOUT_LAST);

  always_comb begin
    pass_sh_d = pass_sh_q;
    tnum_sh_d = tnum_sh_q;
    if (clr) begin
      pass_sh_d = '0;
      tnum_sh_d = '0;
    end else begin
      if (wr_nz && (wb_addr == PASS_IDX)) pass_sh_d = wb_data;
      if (wr_nz && (wb_addr == TNUM_IDX)) tnum_sh_d = wb_data;
    end
  end

  // succ samples pass_sh before this cycle's write; terminal states are sticky
  always_comb begin
    state_d = state_q;
    stop_d  = stop_q;
    succ_d  = succ_q;
    if (clr) begin
      state_d = TM_RUN;
      stop_d  = 1'b0;
      succ_d  = 1'b0;
    end else if (state_q == TM_RUN) begin
      if (done_wr) begin
        state_d = TM_DONE;
        stop_d  = 1'b1;
        succ_d  = (pass_sh_q == DATA_W'(1));
      end else if (timeout_hit) begin
        state_d = TM_TOUT;
        stop_d  = 1'b1;
      end else if (hang_hit) begin
        state_d = TM_HANG;
        stop_d  = 1'b1;
      end
    end
    status_d = status_of(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= TM_RUN;
      stop_q    <= 1'b0;
      succ_q    <= 1'b0;
      status_q  <= ST_RUNNING;
      pass_sh_q <= '0;
      tnum_sh_q <= '0;
    end else begin
      state_q   <= state_d;
      stop_q    <= stop_d;
      succ_q    <= succ_d;
      status_q  <= status_d;
      pass_sh_q <= pass_sh_d;
      tnum_sh_q <= tnum_sh_d;
    end
  end

  // The exit edge does not count, so a timeout freezes at TIMEOUT-1
  assign cyc_inc = (state_q == TM_RUN) && (state_d == TM_RUN);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (cyc_inc),
    .value (cycle_val)
  );

`ifdef TEST_MONITOR_HANG_EN
  logic [ADDR_W-1:0] last_pc_d, last_pc_q;
  logic [LC_W-1:0]   loop_val;
  logic              pc_same, loop_clr;

  assign pc_same  = pc_vld && (pc == last_pc_q);
  assign loop_clr = clr || (pc_vld && !pc_same);
  assign hang_hit = pc_same && (loop_val == LC_W'(LOOP_CNT - 1));

  always_comb begin
    last_pc_d = last_pc_q;
    if (clr) begin
      last_pc_d = '0;
    end else if (pc_vld) begin
      last_pc_d = pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_pc_q <= '0;
    end else begin
      last_pc_q <= last_pc_d;
    end
  end

  sat_counter #(.W(LC_W)) u_loop_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (loop_clr),
    .inc   (pc_same),
    .value (loop_val)
  );
`else
  logic unused_pc;
  assign unused_pc = ^{pc_vld, pc};
  assign hang_hit  = 1'b0;
`endif

  assign stop      = stop_q;
  assign succ      = succ_q;
  assign status    = status_q;
  assign test_num  = tnum_sh_q;
  assign cycle_cnt = cycle_val;

endmodule
